fp_op_scheduler: RTL and testbench

- Shares one floating_multiplier and one floating_adder instance (both 32-bit IEEE-754 single precision, combinational) between NUM_REQ requesters.
- Each requester issues operations over a valid/ready handshake. A round-robin arbiter grants one request per cycle.
- The granted operation goes through a 2-stage registered pipeline: operand register, then result register.
- Results return on a single response channel tagged with requester ID, with resp_ready backpressure.

---
 rtl/fp_sched_pkg.sv | 19 +
 rtl/floating_adder.sv | 84 ++++++++
 rtl/floating_multiplier.sv | 63 ++++++
 rtl/fp_rr_arbiter.sv | 42 ++++
 rtl/fp_op_scheduler.sv | 117 +++++++++++
 tb/tb_fp_op_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp_sched_pkg
// Brief  : Shared opcodes, widths and helpers for the FP operation scheduler
// Rev    : 1.0  initial release
// ============================================================================
package fp_sched_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_ADD = 1'b1;
    localparam int   FP_W   = 32;

    // Bits needed to encode a requester index (at least one bit)
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/floating_adder.sv
`default_nettype none
// ============================================================================
// Module : floating_adder
// Brief  : Combinational IEEE-754 single-precision add, round to nearest
//          even; subnormal inputs and underflowing results flush to zero
// Rev    : 1.0  initial release
// ============================================================================
module floating_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);
    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [31:0]       w_big, w_small;
    logic [27:0]       w_mbig, w_msmall, w_shift, w_sum;
    logic [7:0]        w_diff;
    logic [4:0]        w_lz;
    logic              w_found, w_g, w_st;
    logic [24:0]       w_mant;
    logic signed [9:0] w_exp;

    assign w_a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
    assign w_b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
    assign w_a_inf = (a_i[30:23] == 8'hFF) && (a_i[22:0] == '0);
    assign w_b_inf = (b_i[30:23] == 8'hFF) && (b_i[22:0] == '0);

    // Align the smaller magnitude with guard/round/sticky, add, normalise, round
    always_comb begin
        w_big    = (a_i[30:0] < b_i[30:0]) ? b_i : a_i;
        w_small  = (a_i[30:0] < b_i[30:0]) ? a_i : b_i;
        w_mbig   = {2'b01, w_big[22:0], 3'b000};
        w_msmall = (w_small[30:23] == 8'h00) ? '0 : {2'b01, w_small[22:0], 3'b000};
        w_diff   = w_big[30:23] - w_small[30:23];
        if (w_diff > 8'd27)
            w_shift = {27'b0, |w_msmall};
        else
            w_shift = (w_msmall >> w_diff)
                    | {27'b0, |(w_msmall & ((28'd1 << w_diff) - 28'd1))};
        w_sum = (w_big[31] == w_small[31]) ? (w_mbig + w_shift) : (w_mbig - w_shift);
        w_exp = $signed({2'b00, w_big[30:23]});
        if (w_sum[27]) begin
            w_sum = {1'b0, w_sum[27:1]} | {27'b0, w_sum[0]};
            w_exp = w_exp + 10'sd1;
        end
        w_lz    = '0;
        w_found = 1'b0;
        for (int i = 0; i < 27; i++) begin
            if (!w_found && w_sum[26-i]) begin
                w_lz    = 5'(i);
                w_found = 1'b1;
            end
        end
        w_sum  = w_sum << w_lz;
        w_exp  = w_exp - $signed({5'b0, w_lz});
        w_g    = w_sum[2];
        w_st   = |w_sum[1:0];
        w_mant = {1'b0, w_sum[26:3]} + {24'b0, w_g & (w_st | w_sum[3])};
        if (w_mant[24]) begin
            w_mant = w_mant >> 1;
            w_exp  = w_exp + 10'sd1;
        end
        if (w_a_nan || w_b_nan)
            sum_o = c_QNAN;
        else if (w_a_inf && w_b_inf)
            sum_o = (a_i[31] == b_i[31]) ? a_i : c_QNAN;
        else if (w_a_inf)
            sum_o = a_i;
        else if (w_b_inf)
            sum_o = b_i;
        else if ((w_big[30:23] == 8'h00) || !w_found)
            // Exact cancellation gives +0; only -0 + -0 keeps the sign
            sum_o = ((w_big[30:23] == 8'h00) && a_i[31] && b_i[31]) ? 32'h8000_0000 : 32'h0;
        else if (w_exp >= 10'sd255)
            sum_o = {w_big[31], 8'hFF, 23'b0};
        else if (w_exp <= 10'sd0)
            sum_o = {w_big[31], 31'b0};
        else
            sum_o = {w_big[31], w_exp[7:0], w_mant[22:0]};
    end

endmodule
`default_nettype wire

// File: rtl/floating_multiplier.sv
`default_nettype none
// ============================================================================
// Module : floating_multiplier
// Brief  : Combinational IEEE-754 single-precision multiply, round to nearest
//          even; subnormal inputs and underflowing results flush to zero
// Rev    : 1.0  initial release
// ============================================================================
module floating_multiplier (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] prod_o
);
    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    logic              w_sign;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [47:0]       w_prod;
    logic [24:0]       w_mant;
    logic              w_g, w_st;
    logic signed [9:0] w_exp;

    assign w_sign   = a_i[31] ^ b_i[31];
    assign w_a_nan  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
    assign w_b_nan  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
    assign w_a_inf  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == '0);
    assign w_b_inf  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == '0);
    assign w_a_zero = (a_i[30:23] == 8'h00);
    assign w_b_zero = (b_i[30:23] == 8'h00);

    // Significand product, normalise by at most one place, then round
    always_comb begin
        w_prod = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
        w_exp  = $signed({2'b00, a_i[30:23]}) + $signed({2'b00, b_i[30:23]}) - 10'sd127;
        if (w_prod[47]) begin
            w_g   = w_prod[23];
            w_st  = |w_prod[22:0];
            w_mant = {1'b0, w_prod[47:24]} + {24'b0, w_g & (w_st | w_prod[24])};
            w_exp = w_exp + 10'sd1;
        end else begin
            w_g   = w_prod[22];
            w_st  = |w_prod[21:0];
            w_mant = {1'b0, w_prod[46:23]} + {24'b0, w_g & (w_st | w_prod[23])};
        end
        if (w_mant[24]) begin
            w_mant = w_mant >> 1;
            w_exp  = w_exp + 10'sd1;
        end
        if (w_a_nan || w_b_nan)
            prod_o = c_QNAN;
        else if (w_a_inf || w_b_inf)
            prod_o = (w_a_zero || w_b_zero) ? c_QNAN : {w_sign, 8'hFF, 23'b0};
        else if (w_a_zero || w_b_zero)
            prod_o = {w_sign, 31'b0};
        else if (w_exp >= 10'sd255)
            prod_o = {w_sign, 8'hFF, 23'b0};
        else if (w_exp <= 10'sd0)
            prod_o = {w_sign, 31'b0};
        else
            prod_o = {w_sign, w_exp[7:0], w_mant[22:0]};
    end

endmodule
`default_nettype wire

// File: rtl/fp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fp_rr_arbiter
// Brief  : Round-robin arbiter; search starts one past the last winner
// Rev    : 1.0  initial release
// ============================================================================
module fp_rr_arbiter
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_grant_o
);
    logic w_found;

    // Wrap-around priority search from ptr_i+1; grant only when enabled
    always_comb begin
        int idx;
        grant_o     = '0;
        grant_idx_o = '0;
        w_found     = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!w_found && req_i[idx]) begin
                w_found     = 1'b1;
                grant_idx_o = IDX_W'(idx);
            end
        end
        any_grant_o = w_found & enable_i;
        if (any_grant_o)
            grant_o[grant_idx_o] = 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/fp_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module : fp_op_scheduler
// Brief  : Shares one FP multiplier and one FP adder among NUM_REQ requesters
//          through a round-robin arbiter and a 2-stage registered pipeline
// Rev    : 1.0  initial release
// ============================================================================
module fp_op_scheduler
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ-1:0]      req_op_i,
    input  logic [NUM_REQ*FP_W-1:0] req_a_i,
    input  logic [NUM_REQ*FP_W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [FP_W-1:0]         resp_data_o,
    output logic [ID_W-1:0]         resp_id_o,
    output logic                    resp_op_o,
    output logic [CNT_W-1:0]        ops_done_o
);
    localparam int c_IDX_W = id_width(NUM_REQ);

    logic               s1_valid_q, s1_op_q;
    logic [FP_W-1:0]    s1_a_q, s1_b_q;
    logic [c_IDX_W-1:0] s1_id_q, rr_ptr_q;
    logic               s2_valid_q, s2_op_q;
    logic [FP_W-1:0]    s2_data_q;
    logic [ID_W-1:0]    s2_id_q;
    logic [CNT_W-1:0]   ops_done_q;

    logic               w_s1_ready, w_s2_ready, w_accept;
    logic [c_IDX_W-1:0] w_grant_idx;
    logic [FP_W-1:0]    w_mul, w_add, s2_data_d;

    // A stage can take new data if empty or if it empties this cycle
    assign w_s2_ready = !s2_valid_q || resp_ready_i;
    assign w_s1_ready = !s1_valid_q || w_s2_ready;

    fp_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_arb (
        .req_i       (req_valid_i),
        .ptr_i       (rr_ptr_q),
        .enable_i    (w_s1_ready),
        .grant_o     (req_ready_o),
        .grant_idx_o (w_grant_idx),
        .any_grant_o (w_accept)
    );

    floating_multiplier u_mul (.a_i(s1_a_q), .b_i(s1_b_q), .prod_o(w_mul));
    floating_adder      u_add (.a_i(s1_a_q), .b_i(s1_b_q), .sum_o(w_add));

    assign s2_data_d = (s1_op_q == OP_ADD) ? w_add : w_mul;

    // Stage 1: capture the granted request and remember the winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_MUL;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            rr_ptr_q   <= c_IDX_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            s1_valid_q <= 1'b1;
            s1_op_q    <= req_op_i[w_grant_idx];
            s1_a_q     <= req_a_i[int'(w_grant_idx)*FP_W +: FP_W];
            s1_b_q     <= req_b_i[int'(w_grant_idx)*FP_W +: FP_W];
            s1_id_q    <= w_grant_idx;
            rr_ptr_q   <= w_grant_idx;
        end else if (w_s2_ready) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2: latch the selected unit's result; frozen under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            s2_op_q    <= OP_MUL;
        end else if (w_s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
                s2_id_q   <= ID_W'(s1_id_q);
                s2_op_q   <= s1_op_q;
            end
        end
    end

    // Count completed response handshakes, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ops_done_q <= '0;
        else if (s2_valid_q && resp_ready_i)
            ops_done_q <= ops_done_q + CNT_W'(1);
    end

    assign resp_valid_o = s2_valid_q;
    assign resp_data_o  = s2_data_q;
    assign resp_id_o    = s2_id_q;
    assign resp_op_o    = s2_op_q;
    assign ops_done_o   = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_fp_op_scheduler
// Brief  : Self-checking bench for fp_op_scheduler with a queue-based model
// Rev    : 1.0  initial release
// ============================================================================
module tb_fp_op_scheduler;
    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int CW  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid, req_op, req_ready;
    logic [NR*32-1:0]  req_a, req_b;
    logic              resp_valid, resp_ready, resp_op;
    logic [31:0]       resp_data;
    logic [IDW-1:0]    resp_id;
    logic [CW-1:0]     ops_done;

    always #5 clk = ~clk;

    fp_op_scheduler #(.NUM_REQ(NR), .ID_W(IDW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_ready_o  (req_ready),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_id_o    (resp_id),
        .resp_op_o    (resp_op),
        .ops_done_o   (ops_done)
    );

    typedef struct {
        logic [31:0] data;
        int          id;
        logic        op;
        bit          in_s2;
    } ent_t;

    ent_t        q[$];
    int          checks = 0, errors = 0;
    bit          p_valid[NR];
    logic        p_op[NR];
    logic [31:0] p_a[NR], p_b[NR], p_exp[NR];
    bit          keep_valid;
    int          m_ptr, m_done, last_win, acc_cnt, completed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Exact single-precision encoding of a small integer
    function automatic logic [31:0] fbits(input int v);
        int m, e;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + e);
        r[22:0]  = 23'((m << (23 - e)) & 32'h007F_FFFF);
        return r;
    endfunction

    function automatic void set_req(input int i, input logic op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] exp);
        p_valid[i] = 1'b1;
        p_op[i]    = op;
        p_a[i]     = a;
        p_b[i]     = b;
        p_exp[i]   = exp;
    endfunction

    // Random integer-valued operands so the exact result is known
    function automatic void new_rand(input int i);
        int va, vb, pr;
        logic op;
        logic [31:0] exp;
        va = int'($urandom_range(0, 200)) - 100;
        vb = int'($urandom_range(0, 200)) - 100;
        op = 1'($urandom_range(0, 1));
        if (op == 1'b0) begin
            pr  = va * vb;
            exp = (pr == 0) ? {((va < 0) ^ (vb < 0)), 31'b0} : fbits(pr);
        end else begin
            exp = fbits(va + vb);
        end
        set_req(i, op, fbits(va), fbits(vb), exp);
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = p_valid[i];
            req_op[i]            = p_op[i];
            req_a[32*i +: 32]    = p_a[i];
            req_b[32*i +: 32]    = p_b[i];
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_ptr  = NR - 1;
        m_done = 0;
        for (int i = 0; i < NR; i++) begin
            p_valid[i] = 1'b0;
            p_op[i]    = 1'b0;
            p_a[i]     = '0;
            p_b[i]     = '0;
            p_exp[i]   = '0;
        end
    endfunction

    // One clock: check outputs against the model, then advance the model
    task automatic cycle();
        int win;
        bit can, exp_rv;
        logic [NR-1:0] exp_rdy;
        ent_t e;
        drive();
        #1;
        can = (q.size() < 2) || resp_ready;
        win = -1;
        if (can) begin
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (m_ptr + k) % NR;
                if (win < 0 && p_valid[idx]) win = idx;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        exp_rv = (q.size() > 0) && q[0].in_s2;
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("resp_data", resp_data, q[0].data);
            chk("resp_id", 32'(resp_id), 32'(q[0].id));
            chk("resp_op", 32'(resp_op), 32'(q[0].op));
        end
        chk("ops_done", 32'(ops_done), 32'(m_done));
        last_win = win;
        @(posedge clk);
        if (exp_rv && resp_ready) begin
            void'(q.pop_front());
            m_done = (m_done + 1) % (1 << CW);
            completed++;
        end
        if (q.size() > 0 && !q[0].in_s2) begin
            e = q[0];
            e.in_s2 = 1'b1;
            q[0] = e;
        end
        if (win >= 0) begin
            e.data  = p_exp[win];
            e.id    = win;
            e.op    = p_op[win];
            e.in_s2 = 1'b0;
            q.push_back(e);
            m_ptr = win;
            acc_cnt++;
            if (keep_valid) new_rand(win);
            else            p_valid[win] = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        drive();
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drop_all();
        for (int i = 0; i < NR; i++) p_valid[i] = 1'b0;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        keep_valid = 1'b0;
        acc_cnt    = 0;
        completed  = 0;
        last_win   = -1;
        model_reset();
        drive();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'h0);
        chk("rst_resp_op", 32'(resp_op), 32'h0);
        chk("rst_ops_done", 32'(ops_done), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single multiply from requester 1: 2.0 * 3.0
        set_req(1, 1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        repeat (4) cycle();
        chk("mul_ops_done", 32'(ops_done), 32'd1);

        // Single add from requester 3: 1.5 + 2.5
        set_req(3, 1'b1, 32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000);
        repeat (4) cycle();
        chk("add_ops_done", 32'(ops_done), 32'd2);

        // Fairness: everyone valid from reset
        do_reset();
        keep_valid = 1'b1;
        for (int i = 0; i < NR; i++) new_rand(i);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("grant_order", 32'(last_win), 32'(k % NR));
        end
        keep_valid = 1'b0;
        drop_all();
        repeat (3) cycle();

        // Backpressure: stall the response port for 5 cycles mid-stream
        keep_valid = 1'b1;
        new_rand(0);
        new_rand(2);
        resp_ready = 1'b0;
        acc_cnt    = 0;
        repeat (5) cycle();
        chk("bp_accepts", 32'(acc_cnt), 32'd2);
        resp_ready = 1'b1;
        repeat (6) cycle();
        keep_valid = 1'b0;
        drop_all();
        repeat (4) cycle();

        // Random traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++)
                if (!p_valid[i] && ($urandom_range(0, 1) == 1)) new_rand(i);
            cycle();
        end
        drop_all();
        resp_ready = 1'b1;
        repeat (4) cycle();

        // Counter wrap: 17 completions with a 4-bit counter, one requester held valid
        do_reset();
        keep_valid = 1'b1;
        new_rand(2);
        completed = 0;
        for (int n = 0; n < 40 && completed < 17; n++) cycle();
        chk("wrap_ops_done", 32'(ops_done), 32'd1);
        keep_valid = 1'b0;
        drop_all();
        repeat (3) cycle();

        // Reset while both stages hold work
        keep_valid = 1'b1;
        new_rand(0);
        new_rand(1);
        resp_ready = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
        chk("midrst_ops_done", 32'(ops_done), 32'h0);
        keep_valid = 1'b0;
        model_reset();
        resp_ready = 1'b1;
        drive();
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) cycle();
        new_rand(0);
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
